busmaster: RTL and testbench
============================

# busmaster

68030-style asynchronous bus cycle initiator with dynamic bus sizing. It is the initiator end of the protocol that the DRAM controller and the other slaves answer. It turns a single-operand command (byte, word or long, read or write) into one or more /AS-/DS-/DSACK cycles. Intended users are the DMA and memory-test engines on the Playground 68030 board.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for nDSACK0, nDSACK1 and nBERR.
- TIMEOUT, 255: clocks allowed in WAIT before the cycle is aborted.

Ports:
- CLK  in  1  clock. Reset nRST is asynchronous, active-low.
- nRST  in  1  reset, asynchronous, active-low.
- cmd_req  in  1  start request; sampled only in IDLE.
- cmd_addr  in  32  byte address.
- cmd_size  in  2  SIZ encoding: 01 byte, 10 word, 00 long.
- cmd_rnw  in  1  1 = read.
- cmd_wdata  in  32  right-justified write operand.
- busy  out  1  high from acceptance until rsp_done.
- rsp_done  out  1  one-clock pulse when the command completes.
- rsp_err  out  2  valid with rsp_done: 0 ok, 1 bus error, 2 timeout, 3 misaligned.
- rsp_rdata  out  32  right-justified read operand, valid with rsp_done.
- A  out  32  bus address.
- SIZ  out  2  remaining-bytes count: 01=1, 10=2, 11=3, 00=4.
- RnW  out  1  bus direction.
- nAS  out  1  address strobe.
- nDS  out  1  data strobe.
- D_out  out  32  write data.
- D_oe  out  1  data bus drive enable.
- D_in  in  32  read data.
- nDSACK0  in  1  port-size acknowledge, async, active-low.
- nDSACK1  in  1  port-size acknowledge, async, active-low.
- nBERR  in  1  bus error, async, active-low.

## Operation
- Reset values: nAS=1, nDS=1, RnW=1, D_oe=0, A=0, SIZ=00, D_out=0, busy=0, rsp_done=0, rsp_err=0, rsp_rdata=0. State is IDLE.
- Alignment check on acceptance:
  - A word at an odd address, or a long with addr[1:0]≠0, completes with err 3 one clock later.
  - No bus cycle is run in that case.
- The operand is held left-justified in a 32-bit buffer R. rem holds the remaining byte count; cur holds the current address.
- The DSACK pair (nDSACK1, nDSACK0) is decoded as:
  - 00: 32-bit port.
  - 01: 16-bit port.
  - 10: 8-bit port.
  - 11: not terminated.
- Port width P is 4, 2 or 1. Bytes transferred per cycle: n = min(rem, P − (cur mod P)).
- Write lanes, with lane 0 = D31:24 and a = cur[1:0]:
  - Lane L ≥ a carries R[L−a] when L−a < rem.
  - Lane 0 carries R[0] when a > 0.
  - Lane 1 carries R[0] when a is odd and R[1] when a = 2.
  - Lane 2 carries R[0] when a = 3.
- Read lanes:
  - 32-bit port: byte i comes from lane a+i.
  - 16-bit port: byte i comes from lane cur[0]+i.
  - 8-bit port: byte comes from lane 0.
- After each successful cycle: R shifts left by 8n, cur advances by n, rem decreases by n.
- States and transitions:
  - IDLE → ADDR on cmd_req.
  - ADDR: drive A, SIZ, RnW. For a write, also drive D_out and set D_oe=1. Always goes to STROBE.
  - STROBE: nAS=0. For a read, also nDS=0. Goes to WAIT.
  - WAIT: for a write, nDS=0 on entry. On a synced termination or nBERR: capture lanes, set nAS=nDS=1, go to RELEASE.
  - RELEASE: wait until the synced DSACK pair is 11 and synced nBERR is 1. Then go to ADDR if rem>0 and there is no error. Otherwise go to DONE.
  - DONE: D_oe=0, RnW=1, rsp_done=1, then IDLE.
- nBERR has priority over DSACK in the same clock: err 1, no bytes captured, no further cycles.
- Timeout: the counter resets on entry to WAIT. When it reaches TIMEOUT: err 2, strobes negate, go directly to DONE.
- cmd_req while busy is ignored.
- Reset during a cycle forces all outputs to their reset values immediately.

## Timing
- T0 is the clock that samples cmd_req. Outputs then change as follows:
  - A, SIZ and RnW are valid at T0+1.
  - nAS falls at T0+2. For a read, nDS also falls at T0+2.
  - For a write, nDS falls at T0+3.
- Termination is recognised SYNC_STAGES clocks after DSACK is asserted at the pins.
- rsp_done follows the last RELEASE exit by 1 clock.
- Read data is sampled in the same clock termination is recognised. The responder holds data until /AS negates.
- Successive sub-cycles leave nAS high for at least 2 clocks.

## Structure
- Package pg_bus_pkg holds the SIZ encodings, DSACK width decode, rsp_err codes and the state enum.
- Sub-module bus_lane_mux is combinational. It covers write lane replication and read byte extraction, from (a, rem, P).

## Test plan
- Long write 0x11223344 to 0x1000 with a 32-bit responder → one cycle, SIZ=00, D_out=0x11223344, err 0.
- Long read from 0x2000 with a 16-bit responder returning 0xAABB then 0xCCDD on D31:16 → two cycles:
  - A=0x2000 with SIZ=00, then A=0x2002 with SIZ=10.
  - rsp_rdata=0xAABBCCDD.
- Long write 0x11223344 to 0x3000 with an 8-bit responder → four cycles.
  - A=0x3000, 0x3001, 0x3002, 0x3003.
  - SIZ=00, 11, 10, 01.
  - D31:24=0x11, 0x22, 0x33, 0x44.
- Byte write 0x5A to 0x4003 → D_out=0x5A5A5A5A. Word read from 0x4001 → err 3 with no nAS activity.
- No acknowledge, TIMEOUT=255 → nAS negates after 255 WAIT clocks, err 2.
- nBERR on the first cycle of a long read from a 16-bit port → single cycle, err 1.
- Reset asserted during WAIT → nAS=1 asynchronously.

Source files
------------

// File: rtl/pg_bus_pkg.sv
// pg_bus_pkg: shared encodings for the 68030-style bus initiator.
// SIZ codes, DSACK port-width decode, response codes and FSM states.
package pg_bus_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_3B   = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ALIGN   = 2'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // {nDSACK1, nDSACK0} -> port width in bytes, 0 = not terminated
    function automatic logic [2:0] dsack_width(input logic [1:0] ack);
        logic [2:0] w;
        case (ack)
            2'b00:   w = 3'd4;
            2'b01:   w = 3'd2;
            2'b10:   w = 3'd1;
            default: w = 3'd0;
        endcase
        return w;
    endfunction

    function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
        logic [2:0] b;
        case (siz)
            SIZ_BYTE: b = 3'd1;
            SIZ_WORD: b = 3'd2;
            SIZ_3B:   b = 3'd3;
            default:  b = 3'd4;
        endcase
        return b;
    endfunction

    function automatic logic misaligned(input logic [1:0] siz,
                                        input logic [1:0] a);
        return (siz == SIZ_WORD && a[0]) ||
               (siz == SIZ_LONG && a != 2'b00);
    endfunction

endpackage

// File: rtl/bus_lane_mux.sv
// bus_lane_mux: write-lane replication and read-byte extraction
// for one bus cycle, given offset a, remaining bytes and port width.
module bus_lane_mux
    import pg_bus_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [2:0]  rem,
    input  logic [2:0]  pw,
    input  logic [31:0] r,
    input  logic [31:0] d_in,
    output logic [31:0] wdata,
    output logic [2:0]  n,
    output logic [31:0] rchunk
);

    logic [31:0] sh;
    logic [3:0]  lim;
    logic [1:0]  off;
    logic [2:0]  room;
    logic [31:0] aligned;

    always_comb begin
        sh    = r >> {a, 3'b000};
        lim   = {2'b00, a} + {1'b0, rem};
        wdata = '0;
        for (int l = 0; l < 4; l++) begin
            if (4'(l) >= {2'b00, a} && 4'(l) < lim)
                wdata[31 - 8*l -: 8] = sh[31 - 8*l -: 8];
        end
        // lanes below the offset repeat the leading operand bytes
        case (a)
            2'd1:    wdata[31:24] = r[31:24];
            2'd2:    wdata[31:16] = r[31:16];
            2'd3:    wdata[31:8]  = {3{r[31:24]}};
            default: ;
        endcase
    end

    always_comb begin
        unique case (1'b1)
            pw == 3'd4: off = a;
            pw == 3'd2: off = {1'b0, a[0]};
            default:    off = 2'd0;
        endcase
        room    = pw - {1'b0, off};
        n       = (pw == 3'd0) ? 3'd0 : ((rem < room) ? rem : room);
        aligned = d_in << {off, 3'b000};
        rchunk  = aligned >> {3'd4 - n, 3'b000};
    end

endmodule

// File: rtl/busmaster.sv
// busmaster: 68030-style /AS-/DS-/DSACK bus cycle initiator with
// dynamic bus sizing; one command becomes one or more bus cycles.
module busmaster
    import pg_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cmd_req,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_rnw,
    input  logic [31:0] cmd_wdata,
    output logic        busy,
    output logic        rsp_done,
    output logic [1:0]  rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] A,
    output logic [1:0]  SIZ,
    output logic        RnW,
    output logic        nAS,
    output logic        nDS,
    output logic [31:0] D_out,
    output logic        D_oe,
    input  logic [31:0] D_in,
    input  logic        nDSACK0,
    input  logic        nDSACK1,
    input  logic        nBERR
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [1:0]  ack_s;
    logic        berr_s;
    logic [2:0]  pw;

    logic [2:0]  st;
    logic [31:0] cur;
    logic [31:0] rbuf;
    logic [31:0] acc;
    logic [2:0]  rem;
    logic        rnw_q;
    logic [1:0]  err;
    logic [15:0] tmo;

    logic [31:0] wdata;
    logic [31:0] rchunk;
    logic [2:0]  n;

    assign ack_s  = sync_q[SYNC_STAGES-1][2:1];
    assign berr_s = sync_q[SYNC_STAGES-1][0];
    assign pw     = dsack_width(ack_s);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= {nDSACK1, nDSACK0, nBERR};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    bus_lane_mux u_mux (
        .a      (cur[1:0]),
        .rem    (rem),
        .pw     (pw),
        .r      (rbuf),
        .d_in   (D_in),
        .wdata  (wdata),
        .n      (n),
        .rchunk (rchunk)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st        <= ST_IDLE;
            cur       <= '0;
            rbuf      <= '0;
            acc       <= '0;
            rem       <= '0;
            rnw_q     <= 1'b1;
            err       <= ERR_OK;
            tmo       <= '0;
            busy      <= 1'b0;
            rsp_done  <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= '0;
            A         <= '0;
            SIZ       <= SIZ_LONG;
            RnW       <= 1'b1;
            nAS       <= 1'b1;
            nDS       <= 1'b1;
            D_out     <= '0;
            D_oe      <= 1'b0;
        end else begin
            rsp_done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (cmd_req) begin
                        busy  <= 1'b1;
                        cur   <= cmd_addr;
                        rnw_q <= cmd_rnw;
                        acc   <= '0;
                        rem   <= siz_bytes(cmd_size);
                        rbuf  <= cmd_wdata
                                 << {3'd4 - siz_bytes(cmd_size), 3'b000};
                        if (misaligned(cmd_size, cmd_addr[1:0])) begin
                            err <= ERR_ALIGN;
                            st  <= ST_DONE;
                        end else begin
                            err <= ERR_OK;
                            st  <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    A   <= cur;
                    SIZ <= rem[1:0];
                    RnW <= rnw_q;
                    if (!rnw_q) begin
                        D_out <= wdata;
                        D_oe  <= 1'b1;
                    end
                    st <= ST_STROBE;
                end
                ST_STROBE: begin
                    nAS <= 1'b0;
                    if (rnw_q)
                        nDS <= 1'b0;
                    tmo <= '0;
                    st  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!berr_s) begin
                        err <= ERR_BUS;
                        nAS <= 1'b1;
                        nDS <= 1'b1;
                        st  <= ST_RELEASE;
                    end else if (pw != 3'd0) begin
                        rbuf <= rbuf << {n, 3'b000};
                        cur  <= cur + 32'(n);
                        rem  <= rem - n;
                        if (rnw_q)
                            acc <= (acc << {n, 3'b000}) | rchunk;
                        nAS <= 1'b1;
                        nDS <= 1'b1;
                        st  <= ST_RELEASE;
                    end else if (tmo == TMO_LAST) begin
                        err <= ERR_TIMEOUT;
                        nAS <= 1'b1;
                        nDS <= 1'b1;
                        st  <= ST_DONE;
                    end else begin
                        tmo <= tmo + 16'd1;
                        nDS <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    // responder must let go before the next cycle starts
                    if (ack_s == 2'b11 && berr_s) begin
                        if (rem != 3'd0 && err == ERR_OK)
                            st <= ST_ADDR;
                        else
                            st <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    D_oe      <= 1'b0;
                    RnW       <= 1'b1;
                    rsp_done  <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= acc;
                    busy      <= 1'b0;
                    st        <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_busmaster.sv
// tb_busmaster: directed checks of the bus initiator against a
// behavioural DSACK responder with selectable port width.
module tb_busmaster;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        cmd_req;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic        cmd_rnw;
    logic [31:0] cmd_wdata;
    logic        busy;
    logic        rsp_done;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] A;
    logic [1:0]  SIZ;
    logic        RnW;
    logic        nAS;
    logic        nDS;
    logic [31:0] D_out;
    logic        D_oe;
    logic [31:0] D_in = 32'h0;
    logic        nDSACK0 = 1'b1;
    logic        nDSACK1 = 1'b1;
    logic        nBERR = 1'b1;

    int checks = 0;
    int failures = 0;

    int   mode;
    logic berr_mode;
    int   ncyc = 0;
    int   nas_low = 0;
    logic acked = 1'b0;

    logic [31:0] log_a   [32];
    logic [31:0] log_d   [32];
    logic [1:0]  log_siz [32];
    logic [31:0] rd_q    [32];

    logic [1:0] siz8 [4] = '{2'b00, 2'b11, 2'b10, 2'b01};

    always #5 CLK = ~CLK;

    busmaster #(.SYNC_STAGES(2), .TIMEOUT(255)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .cmd_req   (cmd_req),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_rnw   (cmd_rnw),
        .cmd_wdata (cmd_wdata),
        .busy      (busy),
        .rsp_done  (rsp_done),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .A         (A),
        .SIZ       (SIZ),
        .RnW       (RnW),
        .nAS       (nAS),
        .nDS       (nDS),
        .D_out     (D_out),
        .D_oe      (D_oe),
        .D_in      (D_in),
        .nDSACK0   (nDSACK0),
        .nDSACK1   (nDSACK1),
        .nBERR     (nBERR)
    );

    // responder: acknowledges each /AS once, releases when /AS negates
    always @(negedge CLK) begin
        if (!nAS)
            nas_low++;
        if (nAS) begin
            nDSACK0 = 1'b1;
            nDSACK1 = 1'b1;
            nBERR   = 1'b1;
            acked   = 1'b0;
        end else if (!acked && mode != 0) begin
            if (ncyc < 32) begin
                log_a[ncyc]   = A;
                log_d[ncyc]   = D_out;
                log_siz[ncyc] = SIZ;
                D_in          = rd_q[ncyc];
            end
            ncyc++;
            acked   = 1'b1;
            nDSACK1 = (mode == 1);
            nDSACK0 = (mode == 2);
            nBERR   = !berr_mode;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ad, input logic [1:0] sz,
                         input logic rnw, input logic [31:0] wd);
        @(negedge CLK);
        cmd_addr  = ad;
        cmd_size  = sz;
        cmd_rnw   = rnw;
        cmd_wdata = wd;
        cmd_req   = 1'b1;
        @(negedge CLK);
        cmd_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!rsp_done && i < 2000) begin
            @(negedge CLK);
            i++;
        end
        chk($sformatf("%s_done", tag), 32'(rsp_done), 32'd1);
    endtask

    initial begin
        int b;
        int nl;
        for (int k = 0; k < 32; k++)
            rd_q[k] = 32'h0;
        nRST = 1'b0;
        cmd_req = 1'b0;
        cmd_addr = '0;
        cmd_size = 2'b00;
        cmd_rnw = 1'b1;
        cmd_wdata = '0;
        mode = 0;
        berr_mode = 1'b0;
        repeat (3) @(negedge CLK);

        chk("rst_nas", 32'(nAS), 32'd1);
        chk("rst_nds", 32'(nDS), 32'd1);
        chk("rst_rnw", 32'(RnW), 32'd1);
        chk("rst_doe", 32'(D_oe), 32'd0);
        chk("rst_a", A, 32'd0);
        chk("rst_siz", 32'(SIZ), 32'd0);
        chk("rst_dout", D_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(rsp_done), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        nRST = 1'b1;

        // long write, 32-bit port, with strobe timing
        mode = 4;
        b = ncyc;
        issue(32'h1000, 2'b00, 1'b0, 32'h11223344);
        chk("lw_busy", 32'(busy), 32'd1);
        @(negedge CLK);
        chk("lw_a_t1", A, 32'h1000);
        chk("lw_rnw_t1", 32'(RnW), 32'd0);
        chk("lw_nas_t1", 32'(nAS), 32'd1);
        @(negedge CLK);
        chk("lw_nas_t2", 32'(nAS), 32'd0);
        chk("lw_nds_t2", 32'(nDS), 32'd1);
        @(negedge CLK);
        chk("lw_nds_t3", 32'(nDS), 32'd0);
        chk("lw_doe", 32'(D_oe), 32'd1);
        wait_done("lw");
        chk("lw_err", 32'(rsp_err), 32'd0);
        chk("lw_ncyc", 32'(ncyc - b), 32'd1);
        chk("lw_siz", 32'(log_siz[b]), 32'd0);
        chk("lw_d", log_d[b], 32'h11223344);
        chk("lw_busy_end", 32'(busy), 32'd0);

        // long read, 16-bit port; a request while busy is ignored
        mode = 2;
        b = ncyc;
        rd_q[b]   = 32'hAABB_0000;
        rd_q[b+1] = 32'hCCDD_0000;
        issue(32'h2000, 2'b00, 1'b1, 32'h0);
        @(negedge CLK);
        cmd_addr = 32'h7000;
        cmd_req  = 1'b1;
        @(negedge CLK);
        cmd_req = 1'b0;
        chk("lr_nas_t2", 32'(nAS), 32'd0);
        chk("lr_nds_t2", 32'(nDS), 32'd0);
        wait_done("lr");
        chk("lr_rdata", rsp_rdata, 32'hAABBCCDD);
        chk("lr_err", 32'(rsp_err), 32'd0);
        chk("lr_ncyc", 32'(ncyc - b), 32'd2);
        chk("lr_a0", log_a[b], 32'h2000);
        chk("lr_siz0", 32'(log_siz[b]), 32'd0);
        chk("lr_a1", log_a[b+1], 32'h2002);
        chk("lr_siz1", 32'(log_siz[b+1]), 32'd2);
        repeat (10) @(negedge CLK);
        chk("lr_idle_busy", 32'(busy), 32'd0);
        chk("lr_no_extra", 32'(ncyc - b), 32'd2);

        // long write, 8-bit port
        mode = 1;
        b = ncyc;
        issue(32'h3000, 2'b00, 1'b0, 32'h11223344);
        wait_done("w8");
        chk("w8_err", 32'(rsp_err), 32'd0);
        chk("w8_ncyc", 32'(ncyc - b), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w8_a%0d", k), log_a[b+k], 32'h3000 + 32'(k));
            chk($sformatf("w8_siz%0d", k), 32'(log_siz[b+k]), 32'(siz8[k]));
            chk($sformatf("w8_d%0d", k), 32'(log_d[b+k][31:24]),
                32'(8'h11 * 8'(k + 1)));
        end

        // byte write at offset 3: replicated on every lane
        mode = 4;
        b = ncyc;
        issue(32'h4003, 2'b01, 1'b0, 32'h0000005A);
        wait_done("bw");
        chk("bw_d", log_d[b], 32'h5A5A5A5A);
        chk("bw_a", log_a[b], 32'h4003);
        chk("bw_siz", 32'(log_siz[b]), 32'd1);
        chk("bw_err", 32'(rsp_err), 32'd0);

        // misaligned word read: err 3 one clock later, no /AS
        nl = nas_low;
        issue(32'h4001, 2'b10, 1'b1, 32'h0);
        chk("mis_done_t0", 32'(rsp_done), 32'd0);
        @(negedge CLK);
        chk("mis_done_t1", 32'(rsp_done), 32'd1);
        chk("mis_err", 32'(rsp_err), 32'd3);
        repeat (3) @(negedge CLK);
        chk("mis_no_as", 32'(nas_low - nl), 32'd0);

        // no acknowledge: timeout after 255 WAIT clocks
        mode = 0;
        b = ncyc;
        nl = nas_low;
        issue(32'h5000, 2'b00, 1'b1, 32'h0);
        wait_done("to");
        chk("to_err", 32'(rsp_err), 32'd2);
        chk("to_as_clks", 32'(nas_low - nl), 32'd255);

        // bus error with DSACK in the same clock: one cycle, nothing kept
        mode = 2;
        berr_mode = 1'b1;
        b = ncyc;
        rd_q[b] = 32'h1234_0000;
        issue(32'h6000, 2'b00, 1'b1, 32'h0);
        wait_done("be");
        chk("be_err", 32'(rsp_err), 32'd1);
        chk("be_ncyc", 32'(ncyc - b), 32'd1);
        chk("be_rdata", rsp_rdata, 32'd0);
        repeat (10) @(negedge CLK);
        chk("be_no_extra", 32'(ncyc - b), 32'd1);
        berr_mode = 1'b0;

        // reset in the middle of WAIT clears strobes without a clock edge
        mode = 0;
        issue(32'h8000, 2'b00, 1'b1, 32'h0);
        repeat (5) @(negedge CLK);
        chk("ar_nas_pre", 32'(nAS), 32'd0);
        #2;
        nRST = 1'b0;
        #1;
        chk("ar_nas", 32'(nAS), 32'd1);
        chk("ar_nds", 32'(nDS), 32'd1);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_rnw", 32'(RnW), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("ar_err", 32'(rsp_err), 32'd0);
        chk("ar_a", A, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
